// File: rtl/mem_ack_responder.sv
// Memory-side responder for the cache miss/write-back bus.
// Services one rd/wr request at a time from a word-addressed SRAM and returns a one-cycle ACK.
module mem_ack_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 3,
    parameter              INIT_FILE = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr_mem,
    input  logic        i_rd_mem,
    input  logic        i_wr_mem,
    input  logic [31:0] i_data_mem,
    output logic [31:0] o_data_mem,
    output logic        o_ACK,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [31:0]         data_q, data_d;

    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                commit;
    logic                commit_wr;
    logic [ADDR_W-1:0]   commit_idx;
    logic [31:0]         commit_wdata;
    logic [ADDR_W-1:0]   in_idx;
    logic                unused_addr;

    assign in_idx      = i_addr_mem[ADDR_W+1:2];
    assign unused_addr = ^{i_addr_mem[31:ADDR_W+2], i_addr_mem[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        data_d       = data_q;
        commit       = 1'b0;
        commit_wr    = wr_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
        accept       = (state_q != StWait) && (i_rd_mem || i_wr_mem);

        unique case (state_q)
            StIdle, StResp: begin
                state_d = StIdle;
                if (accept) begin
                    idx_d   = in_idx;
                    wdata_d = i_data_mem;
                    wr_d    = i_wr_mem;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the accept edge is also the commit edge.
                        state_d      = StResp;
                        commit       = 1'b1;
                        commit_wr    = i_wr_mem;
                        commit_idx   = in_idx;
                        commit_wdata = i_data_mem;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit && !commit_wr) begin
            data_d = mem[commit_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    // Array is not reset; a write still in flight when reset hits is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && commit && commit_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign o_data_mem = data_q;
    assign o_ACK      = (state_q == StResp);
    assign o_busy     = (state_q != StIdle);

endmodule
